// File: rtl/stc_pkg.sv
// Shared definitions for the sparse tensor core row-buffer drain engine:
// FSM state encoding and the beat/row geometry helpers.
package stc_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_READ   = 2'd1;
  localparam logic [1:0] ST_SEND   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    READ   = ST_READ,
    SEND   = ST_SEND,
    FINISH = ST_FINISH
  } stc_state_e;

  // Row-count width for the default DW_COL=4 configuration (one extra bit so M itself fits)
  localparam int RC_W_DEFAULT = 5;

  function automatic int rc_width(input int dw_col);
    return dw_col + 1;
  endfunction

  // Number of memory beats that make up one buffer row
  function automatic int beats_of(input int n, input int dw_data, input int dw_mem);
    return (n * dw_data) / dw_mem;
  endfunction

  function automatic int bytes_per_beat(input int dw_mem);
    return dw_mem / 8;
  endfunction

endpackage

// File: rtl/stc_row_serializer.sv
// Row register plus beat counter: captures one buffer row and presents it
// to the memory port as a sequence of DW_MEM-wide beats, low beat first.
module stc_row_serializer
  import stc_pkg::*;
#(
  parameter int N       = 16,
  parameter int DW_DATA = 32,
  parameter int DW_MEM  = 512
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   advance,
  input  logic [N*DW_DATA-1:0]   row_in,
  output logic [DW_MEM-1:0]      beat_data,
  output logic                   is_last_beat,
  output logic                   row_done
);

  localparam int BEATS = beats_of(N, DW_DATA, DW_MEM);
  localparam int BI_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BI_W-1:0] LAST_BEAT = BI_W'(BEATS - 1);

  logic [N*DW_DATA-1:0] row_q;
  logic [BI_W-1:0]      beat_idx;

  // Capture the row on load and step through its beats on each accepted beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q    <= '0;
      beat_idx <= '0;
    end else if (load) begin
      row_q    <= row_in;
      beat_idx <= '0;
    end else if (advance) begin
      beat_idx <= is_last_beat ? '0 : beat_idx + 1'b1;
    end
  end

  assign beat_data    = row_q[int'(beat_idx)*DW_MEM +: DW_MEM];
  assign is_last_beat = (beat_idx == LAST_BEAT);
  assign row_done     = advance & is_last_beat;

endmodule

// File: rtl/stc_dbuffer_drain.sv
// Drain engine for the sparse tensor core D/C row buffer. Sweeps rows
// 0..rows-1 through the buffer's outside read port and streams each row to
// memory as byte-addressed beats over a valid/ready master port.
module stc_dbuffer_drain
  import stc_pkg::*;
#(
  parameter int M       = 16,
  parameter int N       = 16,
  parameter int DW_MEM  = 512,
  parameter int DW_COL  = 4,
  parameter int DW_DATA = 32,
  parameter int AW      = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DW_COL:0]        row_count,
  input  logic [AW-1:0]          base_addr,
  output logic [DW_COL-1:0]      col_out,
  input  logic [N*DW_DATA-1:0]   D_row_out,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DW_MEM-1:0]      m_data,
  output logic [AW-1:0]          m_addr,
  output logic                   m_last,
  output logic                   busy,
  output logic                   done
);

  localparam int RC_W = rc_width(DW_COL);
  localparam int BPB  = bytes_per_beat(DW_MEM);
  localparam logic [RC_W-1:0] M_RC    = RC_W'(M);
  localparam logic [AW-1:0]   ADDR_INC = AW'(BPB);

  stc_state_e       state;
  logic [RC_W-1:0]  rows;
  logic [DW_COL-1:0] row_idx;
  logic [AW-1:0]    addr;
  logic             zero_done;

  logic handshake;
  logic row_done;
  logic is_last_beat;
  logic last_row;

  assign handshake = m_valid & m_ready;
  assign last_row  = (RC_W'(row_idx) == rows - RC_W'(1));

  stc_row_serializer #(
    .N       (N),
    .DW_DATA (DW_DATA),
    .DW_MEM  (DW_MEM)
  ) u_ser (
    .clk          (clk),
    .reset        (reset),
    .load         (state == READ),
    .advance      (handshake),
    .row_in       (D_row_out),
    .beat_data    (m_data),
    .is_last_beat (is_last_beat),
    .row_done     (row_done)
  );

  // Drain sequencer: row/address bookkeeping and the buffer read index.
  // col_out is set one cycle ahead so D_row_out is settled during READ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rows      <= '0;
      row_idx   <= '0;
      addr      <= '0;
      col_out   <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (row_count == '0) begin
              zero_done <= 1'b1;
            end else begin
              rows    <= (row_count > M_RC) ? M_RC : row_count;
              addr    <= base_addr;
              row_idx <= '0;
              col_out <= '0;
              state   <= READ;
            end
          end
        end
        READ: state <= SEND;
        SEND: begin
          if (handshake) begin
            addr <= addr + ADDR_INC;
            if (row_done) begin
              if (last_row) begin
                state <= FINISH;
              end else begin
                row_idx <= row_idx + 1'b1;
                col_out <= row_idx + 1'b1;
                state   <= READ;
              end
            end
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m_valid = (state == SEND);
  assign m_addr  = addr;
  assign m_last  = m_valid & is_last_beat & last_row;
  assign busy    = (state != IDLE);
  assign done    = (state == FINISH) | zero_done;

endmodule

// File: tb/tb_stc_dbuffer_drain.sv
// Scoreboard bench for stc_dbuffer_drain: a reference model expands each
// start request into the expected beat list; monitors pop and compare.
module tb_stc_dbuffer_drain;

  typedef struct {
    logic [511:0] data;
    logic [31:0]  addr;
    logic         last;
    logic [3:0]   col;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   row_count = '0;
  logic [31:0]  base_addr = '0;
  logic [3:0]   col_out;
  logic [511:0] D_row_out;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [511:0] m_data;
  logic [31:0]  m_addr;
  logic         m_last;
  logic         busy;
  logic         done;

  logic         start2 = 1'b0;
  logic [4:0]   row_count2 = '0;
  logic [31:0]  base_addr2 = '0;
  logic [3:0]   col_out2;
  logic [1023:0] D_row_out2;
  logic         m_valid2;
  logic         m_ready2 = 1'b1;
  logic [511:0] m_data2;
  logic [31:0]  m_addr2;
  logic         m_last2;
  logic         busy2;
  logic         done2;

  logic [511:0]  buf1 [16];
  logic [1023:0] buf2 [16];
  assign D_row_out  = buf1[col_out];
  assign D_row_out2 = buf2[col_out2];

  beat_t q1[$];
  beat_t q2[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int hs2_cnt = 0;
  int last_hs_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int rmode = 0;

  logic         held = 1'b0;
  logic [511:0] h_data;
  logic [31:0]  h_addr;
  logic         h_last;
  beat_t        mon_e;
  beat_t        mon_e2;

  stc_dbuffer_drain dut (
    .clk(clk), .reset(reset), .start(start), .row_count(row_count), .base_addr(base_addr),
    .col_out(col_out), .D_row_out(D_row_out), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_addr(m_addr), .m_last(m_last), .busy(busy), .done(done)
  );

  stc_dbuffer_drain #(.M(16), .N(32), .DW_MEM(512), .DW_COL(4), .DW_DATA(32), .AW(32)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .row_count(row_count2), .base_addr(base_addr2),
    .col_out(col_out2), .D_row_out(D_row_out2), .m_valid(m_valid2), .m_ready(m_ready2),
    .m_data(m_data2), .m_addr(m_addr2), .m_last(m_last2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: rows clamp to 16, beats low-half first, address +64 per beat mod 2**32
  task automatic model_push(input bit sel, input int rc, input logic [31:0] base);
    int nrows;
    int nb;
    logic [31:0]   a;
    logic [1023:0] row;
    beat_t it;
    nrows = (rc > 16) ? 16 : rc;
    nb = sel ? 2 : 1;
    a = base;
    for (int r = 0; r < nrows; r++) begin
      row = sel ? buf2[r] : {512'b0, buf1[r]};
      for (int b = 0; b < nb; b++) begin
        it.data = row[b*512 +: 512];
        it.addr = a;
        it.last = (r == nrows - 1) && (b == nb - 1);
        it.col  = 4'(r);
        if (sel) q2.push_back(it);
        else q1.push_back(it);
        a = a + 32'd64;
      end
    end
  endtask

  task automatic fill_buf1();
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 16; k++) buf1[r][k*32 +: 32] = $urandom();
  endtask

  task automatic do_start(input int rc, input logic [31:0] base, input bit accepted);
    @(posedge clk); #1;
    start = 1'b1;
    row_count = 5'(rc);
    base_addr = base;
    if (accepted) model_push(1'b0, rc, base);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == d0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: no done after %0d cycles", name, budget);
    end else begin
      chk32({name, "_done_after_last"}, 32'(done_cyc), 32'(last_hs_cyc + 1));
      chk32({name, "_queue_empty"}, 32'(q1.size()), 32'd0);
      #1;
      chk32({name, "_idle_after_done"}, {30'd0, busy, done}, 32'd0);
    end
  endtask

  // m_ready pattern generator
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = ~m_ready;
        2: m_ready = 1'($urandom_range(0, 1));
        3: m_ready = 1'b0;
        default: ;
      endcase
    end
  end

  // Beat monitor for the default instance, with stall-stability checks
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk32("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", m_data, h_data);
        chk32("hold_addr", m_addr, h_addr);
        chk32("hold_last", 32'(m_last), 32'(h_last));
      end
      held = 1'b0;
      if (m_valid) begin
        if (m_ready) begin
          if (q1.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: addr %0h with nothing expected", m_addr);
          end else begin
            mon_e = q1.pop_front();
            chk("beat_data", m_data, mon_e.data);
            chk32("beat_addr", m_addr, mon_e.addr);
            chk32("beat_last", 32'(m_last), 32'(mon_e.last));
            chk32("beat_col", 32'(col_out), 32'(mon_e.col));
          end
          hs_cnt++;
          last_hs_cyc = cyc;
        end else begin
          held = 1'b1;
          h_data = m_data;
          h_addr = m_addr;
          h_last = m_last;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Beat monitor for the two-beat-per-row instance
  always @(negedge clk) begin
    if (!reset && m_valid2 && m_ready2) begin
      if (q2.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_beat2: addr %0h with nothing expected", m_addr2);
      end else begin
        mon_e2 = q2.pop_front();
        chk("beat2_data", m_data2, mon_e2.data);
        chk32("beat2_addr", m_addr2, mon_e2.addr);
        chk32("beat2_last", 32'(m_last2), 32'(mon_e2.last));
        chk32("beat2_col", 32'(col_out2), 32'(mon_e2.col));
      end
      hs2_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int d0;
    int rc;
    fill_buf1();
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 32; k++) buf2[r][k*32 +: 32] = 32'(r * 256 + k);

    // Reset state
    #2 reset = 1'b1;
    #1;
    chk32("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", m_data, 512'd0);
    chk32("rst_addr", m_addr, 32'd0);
    chk32("rst_last", 32'(m_last), 32'd0);
    chk32("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk32("rst_col", 32'(col_out), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Four rows, m_ready high, with start latency checks
    rmode = 0;
    hs_cnt = 0;
    do_start(4, 32'h0000_1000, 1'b1);
    chk32("lat_busy_read", 32'(busy), 32'd1);
    chk32("lat_valid_read", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    chk32("lat_valid_send", 32'(m_valid), 32'd1);
    wait_done("t4_ready", 200);
    chk32("t4_ready_beats", 32'(hs_cnt), 32'd4);

    // Same transfer with m_ready toggling
    rmode = 1;
    hs_cnt = 0;
    do_start(4, 32'h0000_1000, 1'b1);
    wait_done("t4_toggle", 200);
    chk32("t4_toggle_beats", 32'(hs_cnt), 32'd4);

    // Zero rows: done pulse only
    rmode = 0;
    do_start(0, 32'h0000_5000, 1'b1);
    chk32("zero_done", 32'(done), 32'd1);
    chk32("zero_valid", 32'(m_valid), 32'd0);
    chk32("zero_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk32("zero_done_pulse", 32'(done), 32'd0);

    // Clamped row count under random backpressure
    rmode = 2;
    hs_cnt = 0;
    fill_buf1();
    do_start(20, 32'h0002_0000, 1'b1);
    wait_done("clamp", 1000);
    chk32("clamp_beats", 32'(hs_cnt), 32'd16);

    // Random transfers
    for (int i = 0; i < 4; i++) begin
      fill_buf1();
      rc = int'($urandom_range(1, 16));
      do_start(rc, $urandom() & 32'hFFFF_FFC0, 1'b1);
      wait_done("rand", 1000);
    end

    // Start while busy is ignored
    rmode = 1;
    do_start(5, 32'h0000_4000, 1'b1);
    repeat (3) @(posedge clk);
    do_start(2, 32'h0000_9000, 1'b0);
    wait_done("busy_start", 400);

    // Address wrap
    rmode = 0;
    do_start(2, 32'hFFFF_FFC0, 1'b1);
    wait_done("wrap", 200);

    // Reset during SEND of row 2 with m_ready low
    rmode = 4;
    m_ready = 1'b1;
    hs_cnt = 0;
    do_start(4, 32'h0000_1000, 1'b1);
    n = 0;
    while (hs_cnt < 2 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk32("mid_valid", 32'(m_valid), 32'd1);
    chk32("mid_col", 32'(col_out), 32'd2);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    chk32("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_data", m_data, 512'd0);
    chk32("mid_rst_addr", m_addr, 32'd0);
    chk32("mid_rst_ctl", {28'd0, m_last, busy, done, 1'b0}, 32'd0);
    chk32("mid_rst_col", 32'(col_out), 32'd0);
    q1.delete();
    #7 reset = 1'b0;
    repeat (3) @(posedge clk);
    chk32("mid_no_done", 32'(done_cnt), 32'(d0));
    rmode = 0;
    do_start(3, 32'h0000_1000, 1'b1);
    wait_done("after_rst", 200);

    // Two beats per row on the wide instance
    @(posedge clk); #1;
    start2 = 1'b1;
    row_count2 = 5'd3;
    base_addr2 = 32'h0000_2000;
    model_push(1'b1, 3, 32'h0000_2000);
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk32("wide_done_seen", 32'(done2), 32'd1);
    chk32("wide_beats", 32'(hs2_cnt), 32'd6);
    chk32("wide_queue_empty", 32'(q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
